// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// Module   : lsu_pkg
// Brief    : Shared constants, funct3 codes, state enum and size helper for
//            the load/store unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

    localparam int unsigned c_DMEM_BYTES = 2048;

    // RV32I load/store funct3 codes
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Access size in bytes; illegal codes return 0 (they are rejected anyway)
    function automatic logic [2:0] f3_size(input logic [2:0] funct3);
        case (funct3)
            c_F3_B, c_F3_BU: f3_size = 3'd1;
            c_F3_H, c_F3_HU: f3_size = 3'd2;
            c_F3_W:          f3_size = 3'd4;
            default:         f3_size = 3'd0;
        endcase
    endfunction

    // Illegal as a load: 011, 110, 111
    function automatic logic f3_illegal(input logic [2:0] funct3);
        f3_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//------------------------------------------------------------------------------
// Module   : lsu_align
// Brief    : Combinational lane alignment: byte-enable mask, shifted store
//            data, and load extraction with sign/zero extension.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rword,
    output logic [7:0]  o_mask,
    output logic [63:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_size_mask;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;

    // Build the size mask and lane-shift both store and load data
    always_comb begin
        case (f3_size(i_funct3))
            3'd1:    w_size_mask = 8'h01;
            3'd2:    w_size_mask = 8'h03;
            3'd4:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'h00;
        endcase
        w_shamt   = {i_byte_off, 3'b000};
        o_mask    = w_size_mask << i_byte_off;
        o_wdata   = {32'h0, i_wdata} << w_shamt;
        w_shifted = 32'(i_rword >> w_shamt);
    end

    // Extend the right-justified load result according to funct3
    always_comb begin
        case (i_funct3)
            c_F3_B:  o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_F3_H:  o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_F3_W:  o_rdata = w_shifted;
            c_F3_BU: o_rdata = {24'h0, w_shifted[7:0]};
            c_F3_HU: o_rdata = {16'h0, w_shifted[15:0]};
            default: o_rdata = 32'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
//------------------------------------------------------------------------------
// Module   : lsu
// Brief    : RV32I load/store unit driving a word-wide byte-enabled data
//            memory; misaligned accesses crossing a word are split in two.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned DMEM_BYTES = c_DMEM_BYTES
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [10:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wren,
    input  logic [31:0] i_dmem_q
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [10:0] r_off;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_split;
    logic [31:0] r_q_lo;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_handshake;
    logic [31:0] w_off;
    logic [2:0]  w_size;
    logic [63:0] w_end;
    logic        w_err;
    logic        w_split;
    logic [10:0] w_word_addr;
    logic [63:0] w_rword;
    logic [7:0]  w_mask;
    logic [63:0] w_wdata64;
    logic [31:0] w_rdata;
    logic        w_wr_en;

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = (r_state == ST_DONE);
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign w_handshake = i_req_valid && o_req_ready;

    // Classify the incoming request: offset, bounds/legality error, split
    always_comb begin
        w_off   = i_req_addr - BASE_ADDR;
        w_size  = f3_size(i_req_funct3);
        w_end   = {32'h0, w_off} + {61'h0, w_size};
        w_err   = f3_illegal(i_req_funct3)
               || (i_req_we && i_req_funct3[2])
               || (w_end > 64'(DMEM_BYTES));
        w_split = ({2'b00, w_off[1:0]} + {1'b0, w_size}) > 4'd4;
    end

    // Second half of a split load comes from the live bus, first half from r_q_lo
    assign w_rword     = (r_state == ST_ACC2) ? {i_dmem_q, r_q_lo} : {32'h0, i_dmem_q};
    assign w_word_addr = {r_off[10:2], 2'b00};
    assign w_wr_en     = r_we && !r_err;

    lsu_align u_align (
        .i_funct3   (r_funct3),
        .i_byte_off (r_off[1:0]),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_mask     (w_mask),
        .o_wdata    (w_wdata64),
        .o_rdata    (w_rdata)
    );

    // Next-state logic and memory-port drive
    always_comb begin
        w_state_nxt  = r_state;
        o_dmem_addr  = 11'h0;
        o_dmem_wdata = 32'h0;
        o_dmem_wren  = 4'h0;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) w_state_nxt = ST_ACC1;
            end
            ST_ACC1: begin
                o_dmem_addr  = w_word_addr;
                o_dmem_wdata = w_wdata64[31:0];
                o_dmem_wren  = w_wr_en ? w_mask[3:0] : 4'h0;
                w_state_nxt  = (r_split && !r_err) ? ST_ACC2 : ST_DONE;
            end
            ST_ACC2: begin
                o_dmem_addr  = w_word_addr + 11'd4;
                o_dmem_wdata = w_wdata64[63:32];
                o_dmem_wren  = w_wr_en ? w_mask[7:4] : 4'h0;
                w_state_nxt  = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, request capture, load capture and response registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'h0;
            r_off       <= 11'h0;
            r_wdata     <= 32'h0;
            r_err       <= 1'b0;
            r_split     <= 1'b0;
            r_q_lo      <= 32'h0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_handshake) begin
                r_we     <= i_req_we;
                r_funct3 <= i_req_funct3;
                r_off    <= w_off[10:0];
                r_wdata  <= i_req_wdata;
                r_err    <= w_err;
                r_split  <= w_split;
            end
            if (r_state == ST_ACC1) r_q_lo <= i_dmem_q;
            if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_we || r_err) ? 32'h0 : w_rdata;
            end else begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= 32'h0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
//------------------------------------------------------------------------------
// Module   : tb_lsu
// Brief    : Self-checking bench for lsu: directed cases plus random traffic
//            against a byte-array reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'h0;
    logic [31:0] i_req_addr = 32'h0;
    logic [31:0] i_req_wdata = 32'h0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [10:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_wren;
    logic [31:0] i_dmem_q;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] mem     [0:2047];
    logic [7:0] ref_mem [0:2047];

    logic [3:0]  rec_wren  [0:8];
    logic [10:0] rec_addr  [0:8];
    logic [31:0] rec_wdata [0:8];
    logic [3:0]  wren_any;
    int          got_lat;
    logic [31:0] got_rdata;
    logic        got_err;

    lsu dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_wren  (o_dmem_wren),
        .i_dmem_q     (i_dmem_q)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural data memory seen by the DUT
    assign i_dmem_q = {mem[{o_dmem_addr[10:2], 2'b11}], mem[{o_dmem_addr[10:2], 2'b10}],
                       mem[{o_dmem_addr[10:2], 2'b01}], mem[{o_dmem_addr[10:2], 2'b00}]};

    always @(posedge i_clk) begin
        for (int n = 0; n < 4; n++)
            if (o_dmem_wren[n]) mem[{o_dmem_addr[10:2], n[1:0]}] <= o_dmem_wdata[8*n +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: outcome of one request computed from the byte array
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic e_err, output int e_lat,
                         output logic [31:0] e_rdata);
        longint size;
        longint val;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e_err   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2])
               || ({32'h0, addr} + size > 2048);
        e_lat   = (!e_err && ((addr % 4) + size > 4)) ? 3 : 2;
        e_rdata = 32'h0;
        if (!e_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val = val + (longint'(ref_mem[addr + i]) << (8 * i));
                if (!f3[2] && size < 4 && ((val >> (8 * size - 1)) & 1) == 1)
                    val = val - (longint'(1) << (8 * size));
                e_rdata = val[31:0];
            end
        end
    endtask

    // Issue one request and record the memory port per cycle until the response
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic seen;
        @(negedge i_clk);
        chk("req_ready", {31'h0, o_req_ready}, 32'h1);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        seen     = 1'b0;
        got_lat  = 0;
        wren_any = 4'h0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge i_clk);
            rec_wren[c]  = o_dmem_wren;
            rec_addr[c]  = o_dmem_addr;
            rec_wdata[c] = o_dmem_wdata;
            wren_any     = wren_any | o_dmem_wren;
            if (o_rsp_valid) begin
                seen      = 1'b1;
                got_lat   = c;
                got_rdata = o_rsp_rdata;
                got_err   = o_rsp_err;
            end
        end
        chk("rsp_seen", {31'h0, seen}, 32'h1);
        @(negedge i_clk);
        chk("rsp_pulse", {31'h0, o_rsp_valid}, 32'h0);
        chk("rsp_idle_data", o_rsp_rdata | {31'h0, o_rsp_err}, 32'h0);
    endtask

    task automatic run_chk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        logic        e_err;
        int          e_lat;
        logic [31:0] e_rdata;
        model(we, f3, addr, wd, e_err, e_lat, e_rdata);
        do_req(we, f3, addr, wd);
        chk($sformatf("err@%h", addr), {31'h0, got_err}, {31'h0, e_err});
        chk($sformatf("lat@%h", addr), got_lat, e_lat);
        chk($sformatf("rdata@%h", addr), got_rdata, e_rdata);
        if (e_err || !we) chk($sformatf("no_write@%h", addr), {28'h0, wren_any}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 2048; i++) begin
            b          = 8'($urandom);
            mem[i]     = b;
            ref_mem[i] = b;
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("rst_ready", {31'h0, o_req_ready}, 32'h1);
        chk("rst_valid", {31'h0, o_rsp_valid}, 32'h0);
        chk("rst_err", {31'h0, o_rsp_err}, 32'h0);
        chk("rst_rdata", o_rsp_rdata, 32'h0);
        chk("rst_wren", {28'h0, o_dmem_wren}, 32'h0);
        chk("rst_addr", {21'h0, o_dmem_addr}, 32'h0);
        chk("rst_wdata", o_dmem_wdata, 32'h0);

        // Aligned word store/load
        run_chk(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw_addr", {21'h0, rec_addr[1]}, 32'h100);
        chk("sw_wren", {28'h0, rec_wren[1]}, 32'hF);
        run_chk(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_val", got_rdata, 32'hDEADBEEF);

        // Split halfword
        run_chk(1'b1, 3'b001, 32'h103, 32'h0000A55A);
        chk("sh_a1", {21'h0, rec_addr[1]}, 32'h100);
        chk("sh_w1", {28'h0, rec_wren[1]}, 32'h8);
        chk("sh_d1", {24'h0, rec_wdata[1][31:24]}, 32'h5A);
        chk("sh_a2", {21'h0, rec_addr[2]}, 32'h104);
        chk("sh_w2", {28'h0, rec_wren[2]}, 32'h1);
        chk("sh_d2", {24'h0, rec_wdata[2][7:0]}, 32'hA5);
        run_chk(1'b0, 3'b001, 32'h103, 32'h0);
        chk("lh_val", got_rdata, 32'hFFFFA55A);
        run_chk(1'b0, 3'b101, 32'h103, 32'h0);
        chk("lhu_val", got_rdata, 32'h0000A55A);

        // Sub-word extraction and extension
        run_chk(1'b1, 3'b010, 32'h100, 32'h12348056);
        run_chk(1'b0, 3'b000, 32'h101, 32'h0);
        chk("lb_val", got_rdata, 32'hFFFFFF80);
        run_chk(1'b0, 3'b100, 32'h101, 32'h0);
        chk("lbu_val", got_rdata, 32'h00000080);
        run_chk(1'b0, 3'b001, 32'h102, 32'h0);
        chk("lh2_val", got_rdata, 32'h00001234);

        // Errors: out of range and illegal funct3
        run_chk(1'b1, 3'b010, 32'h7FE, 32'hCAFEF00D);
        chk("err_sw", {31'h0, got_err}, 32'h1);
        run_chk(1'b0, 3'b010, 32'h800, 32'h0);
        chk("err_lw", {31'h0, got_err}, 32'h1);
        run_chk(1'b0, 3'b011, 32'h100, 32'h0);
        chk("err_f3", {31'h0, got_err}, 32'h1);
        run_chk(1'b1, 3'b100, 32'h100, 32'h0);

        // Reset during ACC1 of a split store
        @(negedge i_clk);
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h1FE;
        i_req_wdata  = 32'h89ABCDEF;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("abort_acc1_wren", {28'h0, o_dmem_wren}, 32'hC);
        chk("abort_acc1_addr", {21'h0, o_dmem_addr}, 32'h1FC);
        i_reset = 1'b0;
        #1;
        chk("abort_wren", {28'h0, o_dmem_wren}, 32'h0);
        chk("abort_valid", {31'h0, o_rsp_valid}, 32'h0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("abort_ready", {31'h0, o_req_ready}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("abort_quiet", {27'h0, o_rsp_valid, o_dmem_wren}, 32'h0);
        end
        run_chk(1'b0, 3'b010, 32'h100, 32'h0);
        run_chk(1'b0, 3'b001, 32'h1FE, 32'h0);
        run_chk(1'b0, 3'b001, 32'h200, 32'h0);

        // Random traffic against the reference model
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 32'h0F0 + $urandom_range(0, 32);
                2:       a = 32'h7F0 + $urandom_range(0, 32);
                default: a = $urandom_range(0, 2047);
            endcase
            if ($urandom_range(0, 49) == 0) a = $urandom;
            run_chk(1'($urandom), 3'($urandom), a, $urandom);
        end

        // Final memory sweep by word loads over the busy region
        for (int w = 32'h0F0; w < 32'h118; w += 4) run_chk(1'b0, 3'b010, w, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
